// File: rtl/dest_ip_lookup_arbiter_pkg.sv
// rtl/dest_ip_lookup_arbiter_pkg.sv - shared constants and width helper for the lookup arbiter
package dest_ip_lookup_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ         = 2;
  localparam int DEFAULT_CMP_WIDTH       = 32;
  localparam int DEFAULT_MAX_OUTSTANDING = 4;

  // Requester tag width; a single requester still needs a 1-bit tag.
  function automatic int tag_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/dest_ip_lookup_arbiter_if.sv
// rtl/dest_ip_lookup_arbiter_if.sv - requester and LUT lookup signals of the arbiter
interface dest_ip_lookup_arbiter_if
  import dest_ip_lookup_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEFAULT_NUM_REQ,
  parameter int CMP_WIDTH = DEFAULT_CMP_WIDTH
);

  logic [NUM_REQ-1:0]           req_vld;
  logic [NUM_REQ*CMP_WIDTH-1:0] req_cmp_data;
  logic [NUM_REQ-1:0]           req_rdy;
  logic [NUM_REQ-1:0]           rsp_vld;
  logic [NUM_REQ-1:0]           rsp_hit;
  logic                         lookup_req;
  logic [CMP_WIDTH-1:0]         lookup_cmp_data;
  logic                         lookup_ack;
  logic                         lookup_hit;

  // Requesters plus the LUT state machine drive this side.
  modport master (
    output req_vld, req_cmp_data, lookup_ack, lookup_hit,
    input  req_rdy, rsp_vld, rsp_hit, lookup_req, lookup_cmp_data
  );

  // The arbiter sits on this side.
  modport slave (
    input  req_vld, req_cmp_data, lookup_ack, lookup_hit,
    output req_rdy, rsp_vld, rsp_hit, lookup_req, lookup_cmp_data
  );

endinterface

// File: rtl/fallthrough_small_fifo.sv
// rtl/fallthrough_small_fifo.sv - small FIFO with the head word visible before rd_en
module fallthrough_small_fifo #(
  parameter int WIDTH          = 1,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;

  assign dout  = mem[rd_ptr];
  assign empty = (depth == '0);

  // Storage write; a push while full is only legal alongside a pop of the same slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   depth <= depth + 1'b1;
        2'b01:   depth <= depth - 1'b1;
        default: depth <= depth;
      endcase
    end
  end

endmodule

// File: rtl/dest_ip_lookup_arbiter.sv
// rtl/dest_ip_lookup_arbiter.sv - round-robin sharing of the destination-IP LUT lookup port
module dest_ip_lookup_arbiter
  import dest_ip_lookup_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = DEFAULT_NUM_REQ,
  parameter int CMP_WIDTH       = DEFAULT_CMP_WIDTH,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int OUTST_BITS      = $clog2(MAX_OUTSTANDING)
) (
  input  logic                     clk,
  input  logic                     reset,
  dest_ip_lookup_arbiter_if.slave  bus,
  output logic                     ack_underflow
);

  localparam int REQ_BITS = tag_width(NUM_REQ);
  localparam int CNT_W    = OUTST_BITS + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [REQ_BITS-1:0]  rr_ptr;
  logic [CNT_W-1:0]     out_cnt;
  logic                 issue_ok;
  logic [REQ_BITS-1:0]  gnt_idx;
  logic                 gnt_any;
  logic [NUM_REQ-1:0]   req_rdy_c;
  logic [CMP_WIDTH-1:0] gnt_key;
  logic [REQ_BITS-1:0]  fifo_tag;
  logic                 fifo_empty;
  logic                 pop;
  logic [NUM_REQ-1:0]   rsp_vld_d;
  logic [NUM_REQ-1:0]   rsp_hit_d;
  logic [NUM_REQ-1:0]   rsp_vld_q;
  logic [NUM_REQ-1:0]   rsp_hit_q;
  logic                 lookup_req_q;
  logic [CMP_WIDTH-1:0] lookup_data_q;

  // A full window can still issue when an ack frees a slot in the same cycle.
  assign issue_ok = (out_cnt < MAX_CNT) || ((out_cnt == MAX_CNT) && bus.lookup_ack);
  assign pop      = bus.lookup_ack && !fifo_empty;

  assign bus.req_rdy         = req_rdy_c;
  assign bus.rsp_vld         = rsp_vld_q;
  assign bus.rsp_hit         = rsp_hit_q;
  assign bus.lookup_req      = lookup_req_q;
  assign bus.lookup_cmp_data = lookup_data_q;

  // Pick the valid requester closest to the round-robin pointer, counting upward with wrap.
  always_comb begin
    int span;
    int best;
    span    = 0;
    best    = NUM_REQ;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      span = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + NUM_REQ - int'(rr_ptr));
      if (bus.req_vld[i] && (span < best)) begin
        best    = span;
        gnt_idx = REQ_BITS'(i);
      end
    end
    gnt_any = issue_ok && (|bus.req_vld);
  end

  // One-hot ready and the key of the granted requester.
  always_comb begin
    req_rdy_c = '0;
    gnt_key   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && (gnt_idx == REQ_BITS'(i))) begin
        req_rdy_c[i] = 1'b1;
        gnt_key      = bus.req_cmp_data[i*CMP_WIDTH +: CMP_WIDTH];
      end
    end
  end

  // Route an ack to the requester whose tag sits at the FIFO head.
  always_comb begin
    rsp_vld_d = '0;
    rsp_hit_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_vld_d[i] = pop && (fifo_tag == REQ_BITS'(i));
      rsp_hit_d[i] = rsp_vld_d[i] && bus.lookup_hit;
    end
  end

  fallthrough_small_fifo #(
    .WIDTH          (REQ_BITS),
    .MAX_DEPTH_BITS (OUTST_BITS)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (gnt_idx),
    .wr_en (gnt_any),
    .rd_en (pop),
    .dout  (fifo_tag),
    .empty (fifo_empty)
  );

  // Registered lookup issue, response pulses and the sticky underflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      lookup_req_q  <= 1'b0;
      lookup_data_q <= '0;
      rsp_vld_q     <= '0;
      rsp_hit_q     <= '0;
      ack_underflow <= 1'b0;
    end else begin
      lookup_req_q  <= gnt_any;
      lookup_data_q <= gnt_any ? gnt_key : '0;
      rsp_vld_q     <= rsp_vld_d;
      rsp_hit_q     <= rsp_hit_d;
      if (bus.lookup_ack && fifo_empty) begin
        ack_underflow <= 1'b1;
      end
    end
  end

  // Round-robin pointer advance and outstanding-lookup count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      out_cnt <= '0;
    end else begin
      if (gnt_any) begin
        rr_ptr <= (gnt_idx == REQ_BITS'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      case ({gnt_any, pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dest_ip_lookup_arbiter.sv
// tb/tb_dest_ip_lookup_arbiter.sv - self-checking bench for the lookup arbiter
module tb_dest_ip_lookup_arbiter;

  localparam int N    = 2;
  localparam int W    = 32;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic reset;
  logic ack_underflow;

  always #5 clk = ~clk;

  dest_ip_lookup_arbiter_if #(.NUM_REQ(N), .CMP_WIDTH(W)) bus ();

  dest_ip_lookup_arbiter #(
    .NUM_REQ         (N),
    .CMP_WIDTH       (W),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .ack_underflow (ack_underflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit           pend_vld [N];
  logic [W-1:0] pend_key [N];
  bit           refill  = 1'b0;
  bit           rst_now = 1'b0;

  // Reference state: requester tags and keys of lookups in flight, in LUT order.
  int           m_tags [$];
  logic [W-1:0] m_keys [$];
  int           m_rr = 0;
  bit           m_uf = 1'b0;

  logic [N-1:0] last_rdy;
  logic [5:0]   seq;
  int           ngr;

  function automatic bit lut_hit(input logic [W-1:0] k);
    return ^k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit ack_in);
    int           g;
    bit           issue_ok;
    bit           hit_now;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [N-1:0] exp_rh;
    logic [W-1:0] g_key;
    reset = rst_now;
    for (int i = 0; i < N; i++) begin
      bus.req_vld[i]            = pend_vld[i];
      bus.req_cmp_data[i*W +: W] = pend_key[i];
    end
    bus.lookup_ack = ack_in;
    hit_now = (m_keys.size() > 0) ? lut_hit(m_keys[0]) : 1'($urandom_range(0, 1));
    bus.lookup_hit = hit_now;
    g = -1;
    issue_ok = (m_tags.size() < MAXO) || ((m_tags.size() == MAXO) && ack_in);
    if (issue_ok) begin
      for (int off = 0; off < N; off++) begin
        if ((g < 0) && pend_vld[(m_rr + off) % N]) g = (m_rr + off) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    @(negedge clk);
    last_rdy = bus.req_rdy;
    chk("req_rdy", last_rdy, exp_rdy);
    @(posedge clk);
    #1;
    exp_rv = '0;
    exp_rh = '0;
    if (rst_now) begin
      m_tags.delete();
      m_keys.delete();
      m_rr = 0;
      m_uf = 1'b0;
      g    = -1;
    end else begin
      if (ack_in) begin
        if (m_tags.size() > 0) begin
          exp_rv[m_tags[0]] = 1'b1;
          exp_rh[m_tags[0]] = hit_now;
          void'(m_tags.pop_front());
          void'(m_keys.pop_front());
        end else begin
          m_uf = 1'b1;
        end
      end
      if (g >= 0) begin
        m_tags.push_back(g);
        m_keys.push_back(pend_key[g]);
        m_rr = (g + 1) % N;
      end
    end
    g_key = (g >= 0) ? pend_key[g] : '0;
    chk("lookup_req", bus.lookup_req, (g >= 0));
    if ((g >= 0) || rst_now) chk("lookup_cmp_data", bus.lookup_cmp_data, g_key);
    chk("rsp_vld", bus.rsp_vld, exp_rv);
    chk("rsp_hit", bus.rsp_hit, exp_rh);
    chk("ack_underflow", ack_underflow, m_uf);
    if (g >= 0) begin
      pend_vld[g] = refill;
      pend_key[g] = $urandom;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) pend_vld[i] = 1'b0;
    rst_now = 1'b1;
    tick(1'b0);
    tick(1'b0);
    rst_now = 1'b0;
  endtask

  task automatic drain();
    refill = 1'b0;
    for (int i = 0; i < N; i++) pend_vld[i] = 1'b0;
    for (int k = 0; (k < 4 * MAXO) && (m_tags.size() > 0); k++) tick(1'b1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend_vld[i] = 1'b0;
      pend_key[i] = '0;
    end
    bus.req_vld      = '0;
    bus.req_cmp_data = '0;
    bus.lookup_ack   = 1'b0;
    bus.lookup_hit   = 1'b0;
    reset            = 1'b1;

    // Reset state
    do_reset();
    chk("reset_rdy", bus.req_rdy, 2'b00);
    chk("reset_lookup_req", bus.lookup_req, 1'b0);

    // Single requester, ack three cycles after the lookup
    pend_vld[0] = 1'b1;
    pend_key[0] = 32'h0A00_0001;
    refill      = 1'b0;
    tick(1'b0);
    chk("t1_lookup_data", bus.lookup_cmp_data, 32'h0A00_0001);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    chk("t1_rsp_vld", bus.rsp_vld, 2'b01);
    chk("t1_rsp_hit", bus.rsp_hit, 2'b01);
    tick(1'b0);

    // Both requesters held valid, ack each cycle: grants alternate
    do_reset();
    pend_vld[0] = 1'b1; pend_key[0] = $urandom;
    pend_vld[1] = 1'b1; pend_key[1] = $urandom;
    refill = 1'b1;
    seq = '0;
    for (int k = 0; k < 6; k++) begin
      tick(k > 0);
      seq = {seq[4:0], last_rdy[1]};
    end
    chk("alt_grants", seq, 6'b010101);
    drain();

    // LUT stall: window fills at MAX_OUTSTANDING, one ack admits one grant
    do_reset();
    pend_vld[0] = 1'b1; pend_key[0] = $urandom;
    pend_vld[1] = 1'b1; pend_key[1] = $urandom;
    refill = 1'b1;
    ngr = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b0);
      if (last_rdy != '0) ngr++;
    end
    chk("stall_grants", ngr, 4);
    chk("stall_rdy", last_rdy, 2'b00);
    tick(1'b1);
    chk("ack_regrant", last_rdy, 2'b01);
    tick(1'b0);
    chk("full_again_rdy", last_rdy, 2'b00);
    drain();

    // Ack with nothing outstanding
    do_reset();
    tick(1'b1);
    chk("uf_set", ack_underflow, 1'b1);
    chk("uf_no_rsp", bus.rsp_vld, 2'b00);
    for (int k = 0; k < 3; k++) tick(1'b0);
    chk("uf_sticky", ack_underflow, 1'b1);
    do_reset();
    chk("uf_cleared", ack_underflow, 1'b0);

    // Reset with three lookups in flight
    pend_vld[0] = 1'b1; pend_key[0] = $urandom;
    pend_vld[1] = 1'b1; pend_key[1] = $urandom;
    refill = 1'b1;
    for (int k = 0; k < 3; k++) tick(1'b0);
    pend_vld[0] = 1'b0;
    pend_vld[1] = 1'b0;
    rst_now = 1'b1;
    tick(1'b0);
    rst_now = 1'b0;
    chk("mid_rst_lookup_req", bus.lookup_req, 1'b0);
    chk("mid_rst_rsp_vld", bus.rsp_vld, 2'b00);
    pend_vld[0] = 1'b1; pend_key[0] = $urandom;
    pend_vld[1] = 1'b1; pend_key[1] = $urandom;
    refill = 1'b0;
    tick(1'b0);
    chk("post_rst_first_grant", last_rdy, 2'b01);
    drain();

    // Randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_vld[i] && ($urandom_range(0, 1) == 1)) begin
          pend_vld[i] = 1'b1;
          pend_key[i] = $urandom;
        end
      end
      refill = 1'($urandom_range(0, 1));
      tick((m_tags.size() > 0) && ($urandom_range(0, 2) != 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dest_ip_lookup_arbiter.md
# dest_ip_lookup_arbiter

Shares the single lookup port of the destination-IP filter CAM/LUT state machine between NUM_REQ independent requesters (e.g. per-port preprocess pipelines). Grants one lookup per cycle round-robin, tracks in-flight lookups with a requester-tag FIFO, and returns each hit/miss result to the requester that issued it. Sits between the requesters and the `unencoded_cam_lut_sm` lookup interface; the register read/write ports of the LUT are untouched.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- CMP_WIDTH, 32, lookup key width (IPv4 address)
- MAX_OUTSTANDING, 4, max lookups issued but not yet acked; power of 2
- OUTST_BITS, log2(MAX_OUTSTANDING), tag FIFO depth bits
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- req_vld  in  NUM_REQ  requester i has a key pending; held until accepted
- req_cmp_data  in  NUM_REQ*CMP_WIDTH  key i at bits [i*CMP_WIDTH +: CMP_WIDTH]
- req_rdy  out  NUM_REQ  combinational grant; transfer when req_vld[i] & req_rdy[i] at clk edge
- rsp_vld  out  NUM_REQ  one-cycle pulse, result for requester i
- rsp_hit  out  NUM_REQ  hit flag, valid with rsp_vld[i]
- lookup_req  out  1  one-cycle pulse to LUT state machine
- lookup_cmp_data  out  CMP_WIDTH  key, valid with lookup_req
- lookup_ack  in  1  LUT result strobe, in issue order
- lookup_hit  in  1  LUT hit, valid with lookup_ack
- ack_underflow  out  1  sticky error: lookup_ack with no lookup outstanding

## Operation
- Reset values: req_rdy, rsp_vld, rsp_hit, lookup_req, lookup_cmp_data, ack_underflow all 0; outstanding count 0; tag FIFO empty; RR pointer 0.
- Issue allowed when outstanding count < MAX_OUTSTANDING, or == MAX_OUTSTANDING with lookup_ack in the same cycle.
- Arbitration: if issue allowed, exactly one req_rdy bit is high: first i with req_vld[i] searching from RR pointer upward, wrapping modulo NUM_REQ. No req_vld: req_rdy = 0.
- On transfer of requester g: RR pointer <- (g+1) mod NUM_REQ; push g into tag FIFO; register key; outstanding count +1.
- On lookup_ack: pop tag t; rsp_vld[t] <= 1, rsp_hit[t] <= lookup_hit; outstanding count -1.
- Simultaneous transfer and ack: push and pop both happen, count unchanged.
- Ack with empty tag FIFO: no rsp_vld; ack_underflow <= 1 until reset; count stays 0.
- Key in req_cmp_data may change only after transfer; arbiter does not hold unaccepted keys.
- Reset mid-operation: all state cleared; the LUT state machine shares the same reset, so no pre-reset acks are expected.

## Timing
- Transfer at edge t -> lookup_req and lookup_cmp_data high for one cycle t+1.
- lookup_ack at edge a -> rsp_vld/rsp_hit at cycle a+1 (registered, one cycle).
- Throughput: one lookup per cycle while LUT acks keep outstanding count below limit.
- Responses to each requester arrive in that requester's issue order; global order equals LUT ack order.
- req_rdy depends combinationally on req_vld, RR pointer, count and lookup_ack; no combinational path from req_vld to lookup_req.

## Structure
- NUM_REQ-dependent widths derived locally; no new entries in defines.vh beyond a default MAX_OUTSTANDING macro `ROUTER_OP_LUT_DST_IP_LOOKUP_MAX_OUTSTANDING.
- Tag FIFO: one instance of `fallthrough_small_fifo` with WIDTH = log2(NUM_REQ) (min 1), MAX_DEPTH_BITS = OUTST_BITS.
- Round-robin priority select and outstanding counter in this module; ~150-250 lines RTL.

## Test plan
- Single requester 0 sends key 0x0A000001, LUT acks hit 3 cycles later -> lookup_req at t+1 with 0x0A000001; rsp_vld[0]=1, rsp_hit[0]=1 one cycle after ack; rsp_vld[1] stays 0.
- Both requesters hold req_vld for 6 cycles, ack every cycle -> grants alternate 0,1,0,1,0,1; responses alternate likewise with hit values matching per-key LUT model.
- LUT stalls (no ack) with MAX_OUTSTANDING=4 -> exactly 4 lookups issued, req_rdy=0 thereafter; single ack in cycle k -> one new grant in cycle k.
- Ack and new transfer in same cycle at count=4 -> count stays 4, tag order preserved, responses route to correct requesters.
- lookup_ack pulsed with nothing outstanding -> no rsp_vld, ack_underflow=1 and stays 1 until reset.
- Assert reset with 3 lookups in flight -> next cycle all outputs 0, RR pointer 0; after release, requester 0 and 1 both valid -> requester 0 granted first.
